// File: rtl/npc_pkg.sv
// npc_pkg: shared definitions for the next-PC sequencer.
//   - MIPS opcode and funct field constants decoded by npc_seq.
//   - npc_state_t: RUN/HALT state of the sequencer.
package npc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_SYSCALL = 6'b001100;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } npc_state_t;

endpackage

// File: rtl/npc_sat_counter.sv
// npc_sat_counter: W-bit saturating event counter.
// Ports:
//   clk  - clock
//   rst  - synchronous reset, active-low (clears the count)
//   inc  - count one event this cycle
//   clr  - clear the count; wins over a simultaneous inc
//   cnt  - current count, sticks at 2^W-1
module npc_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  // NOTE: reset is sampled on the clock edge, so it lives inside the
  // posedge-only block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/npc_seq.sv
// npc_seq: PC register and next-PC logic for the single-cycle MIPS datapath,
// with a RUN/HALT state machine and saturating branch statistics.
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   en              - advance enable (0 = stall)
//   go              - resume pulse, only meaningful while halted
//   clr_stats       - clear all statistics counters
//   instr           - current instruction
//   rs_val, rt_val  - register-file read data
//   sys_val         - $v0 value inspected by SYSCALL
//   pc              - registered PC
//   next_pc         - combinational next PC
//   link_pc         - pc+4, JAL return address
//   halted          - high while in HALT
//   uncond_cnt      - J/JAL/JR count
//   cond_cnt        - BEQ/BNE count
//   cond_taken_cnt  - taken BEQ/BNE count
module npc_seq
  import npc_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                CNT_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]       HALT_CODE = 32'hA
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              go,
  input  logic              clr_stats,
  input  logic [31:0]       instr,
  input  logic [31:0]       rs_val,
  input  logic [31:0]       rt_val,
  input  logic [31:0]       sys_val,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] link_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  uncond_cnt,
  output logic [CNT_W-1:0]  cond_cnt,
  output logic [CNT_W-1:0]  cond_taken_cnt
);

  npc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  logic [5:0]        op, funct;
  logic              is_jump, is_jr, is_sys, is_beq, is_bne;
  logic              is_uncond, is_cond, br_taken, sys_halt;
  logic [ADDR_W-1:0] p4, br_off, br_target, j_target, jr_target, run_next;
  logic              inc_uncond, inc_cond, inc_taken;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  assign p4        = pc_q + ADDR_W'(4);
  assign br_off    = {{(ADDR_W-18){instr[15]}}, instr[15:0], 2'b00};
  assign br_target = p4 + br_off;
  assign jr_target = ADDR_W'(rs_val);

  // The jump region keeps whatever PC bits sit above the 28-bit pseudo-direct
  // field; a 28-bit PC has none.
  if (ADDR_W > 28) begin : g_jregion
    assign j_target = {p4[ADDR_W-1:28], instr[25:0], 2'b00};
  end else begin : g_jflat
    assign j_target = {instr[25:0], 2'b00};
  end

  // Decode and RUN-state next-PC selection.
  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path leaves a signal unassigned (latch).
  always_comb begin
    is_jump   = (op == OP_J) || (op == OP_JAL);
    is_jr     = (op == OP_RTYPE) && (funct == FN_JR);
    is_sys    = (op == OP_RTYPE) && (funct == FN_SYSCALL);
    is_beq    = (op == OP_BEQ);
    is_bne    = (op == OP_BNE);
    is_uncond = is_jump || is_jr;
    is_cond   = is_beq || is_bne;
    br_taken  = (is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val));
    sys_halt  = is_sys && (sys_val == HALT_CODE);

    run_next = p4;
    if (is_jump) begin
      run_next = j_target;
    end else if (is_jr) begin
      run_next = jr_target;
    end else if (br_taken) begin
      run_next = br_target;
    end else if (sys_halt) begin
      run_next = pc_q;
    end
  end

  // State register.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its pre-edge inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      RUN: begin
        if (en) begin
          pc_d = run_next;
          if (sys_halt) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        // Resume one instruction past the SYSCALL that stopped us.
        if (go) begin
          state_d = RUN;
          pc_d    = p4;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs.
  always_comb begin
    halted     = (state_q == HALT);
    next_pc    = halted ? pc_q : run_next;
    inc_uncond = !halted && en && is_uncond;
    inc_cond   = !halted && en && is_cond;
    inc_taken  = !halted && en && br_taken;
  end

  assign pc      = pc_q;
  assign link_pc = p4;

  npc_sat_counter #(.W(CNT_W)) u_uncond_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_uncond),
    .clr (clr_stats),
    .cnt (uncond_cnt)
  );

  npc_sat_counter #(.W(CNT_W)) u_cond_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_cond),
    .clr (clr_stats),
    .cnt (cond_cnt)
  );

  npc_sat_counter #(.W(CNT_W)) u_cond_taken_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inc_taken),
    .clr (clr_stats),
    .cnt (cond_taken_cnt)
  );

endmodule

// File: tb/tb_npc_seq.sv
// tb_npc_seq: directed plus randomized bench for npc_seq, checked against a
// behavioural model of the sequencer kept in plain arithmetic.
module tb_npc_seq;

  localparam int ADDR_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst, en, go, clr_stats;
  logic [31:0]       instr, rs_val, rt_val, sys_val;
  logic [ADDR_W-1:0] pc, next_pc, link_pc;
  logic              halted;
  logic [CNT_W-1:0]  uncond_cnt, cond_cnt, cond_taken_cnt;

  npc_seq #(
    .ADDR_W    (ADDR_W),
    .CNT_W     (CNT_W),
    .RESET_PC  (32'h0),
    .HALT_CODE (32'hA)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .go             (go),
    .clr_stats      (clr_stats),
    .instr          (instr),
    .rs_val         (rs_val),
    .rt_val         (rt_val),
    .sys_val        (sys_val),
    .pc             (pc),
    .next_pc        (next_pc),
    .link_pc        (link_pc),
    .halted         (halted),
    .uncond_cnt     (uncond_cnt),
    .cond_cnt       (cond_cnt),
    .cond_taken_cnt (cond_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  bit          m_halted;
  int          m_unc, m_cond, m_taken;

  function automatic logic [31:0] model_next();
    logic [31:0] p4;
    int          opc, fn, off;
    p4  = m_pc + 32'd4;
    opc = int'(instr >> 26);
    fn  = int'(instr & 32'h3F);
    off = int'($signed(instr[15:0]));
    if (m_halted) return m_pc;
    if (opc == 2 || opc == 3) return (p4 & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    if (opc == 0 && fn == 8) return rs_val;
    if (opc == 4 && rs_val == rt_val) return p4 + 32'(off * 4);
    if (opc == 5 && rs_val != rt_val) return p4 + 32'(off * 4);
    if (opc == 0 && fn == 12 && sys_val == 32'hA) return m_pc;
    return p4;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_halted = 0; m_unc = 0; m_cond = 0; m_taken = 0;
  endtask

  task automatic model_update();
    logic [31:0] nxt;
    int          opc, fn;
    bit          unc, cnd, tkn;
    nxt = model_next();
    opc = int'(instr >> 26);
    fn  = int'(instr & 32'h3F);
    unc = (opc == 2) || (opc == 3) || (opc == 0 && fn == 8);
    cnd = (opc == 4) || (opc == 5);
    tkn = (opc == 4 && rs_val == rt_val) || (opc == 5 && rs_val != rt_val);
    if (!rst) begin
      model_reset();
      return;
    end
    if (m_halted) begin
      if (go) begin
        m_halted = 0;
        m_pc     = m_pc + 32'd4;
      end
    end else if (en) begin
      if (unc && m_unc < CNT_MAX) m_unc++;
      if (cnd && m_cond < CNT_MAX) m_cond++;
      if (tkn && m_taken < CNT_MAX) m_taken++;
      if (opc == 0 && fn == 12 && sys_val == 32'hA) m_halted = 1;
      m_pc = nxt;
    end
    if (clr_stats) begin
      m_unc = 0; m_cond = 0; m_taken = 0;
    end
  endtask

  task automatic check_state();
    check("pc", pc, m_pc);
    check("halted", 32'(halted), 32'(m_halted));
    check("uncond_cnt", 32'(uncond_cnt), 32'(m_unc));
    check("cond_cnt", 32'(cond_cnt), 32'(m_cond));
    check("cond_taken_cnt", 32'(cond_taken_cnt), 32'(m_taken));
  endtask

  // Inputs are already driven; check the pre-edge view, clock once, advance model.
  task automatic step();
    #1;
    check_state();
    check("next_pc", next_pc, model_next());
    check("link_pc", link_pc, m_pc + 32'd4);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] sv, input logic e, input logic g, input logic c);
    instr = i; rs_val = rs; rt_val = rt; sys_val = sv; en = e; go = g; clr_stats = c;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0:       return {6'd2, r[25:0]};
      1:       return {6'd3, r[25:0]};
      2:       return {6'd0, r[25:6], 6'd8};
      3:       return {6'd4, r[25:0]};
      4:       return {6'd5, r[25:0]};
      5:       return {6'd0, r[25:6], 6'd12};
      default: return r;
    endcase
  endfunction

  initial begin
    logic [31:0] rs, rt;

    // Reset.
    rst = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_state();
    rst = 1'b1;

    // J at pc=0.
    drive(32'h0808_4210, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    #1 check("j_next_pc", next_pc, 32'h0021_0840);
    step();
    check("j_pc", pc, 32'h0021_0840);
    check("j_uncond", 32'(uncond_cnt), 32'd1);

    // JR to the top of memory, then a not-taken BNE that wraps to 0.
    drive(32'h0000_0008, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    check("jr_pc", pc, 32'hFFFF_FFFC);
    drive(32'h1400_FFFE, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    check("bne_wrap_pc", pc, 32'h0);
    check("bne_cond", 32'(cond_cnt), 32'd1);
    check("bne_taken", 32'(cond_taken_cnt), 32'd0);

    // BEQ self-loop at 0x100 saturates the taken counter.
    drive(32'h0800_0040, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h1000_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0);
    #1 check("beq_next_pc", next_pc, 32'h100);
    repeat (20) step();
    check("beq_sat", 32'(cond_taken_cnt), 32'hF);

    // Clear beats increment, then stall freezes the counters.
    clr_stats = 1'b1;
    step();
    check("clr_vs_inc", 32'(cond_taken_cnt), 32'd0);
    clr_stats = 1'b0;
    repeat (3) step();
    en = 1'b0;
    repeat (5) step();
    check("stall_taken", 32'(cond_taken_cnt), 32'd3);
    check("stall_pc", pc, 32'h100);
    en = 1'b1;
    repeat (2) step();
    check("resume_taken", 32'(cond_taken_cnt), 32'd5);

    // Halting SYSCALL at 0x40.
    drive(32'h0800_0010, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h0000_000C, 32'h0, 32'h0, 32'hA, 1'b1, 1'b0, 1'b0);
    step();
    check("sys_halted", 32'(halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      instr = rand_instr();
      step();
    end
    check("halt_pc", pc, 32'h40);
    go = 1'b1;
    step();
    go = 1'b0;
    check("go_pc", pc, 32'h44);
    check("go_halted", 32'(halted), 32'd0);

    // Non-halting SYSCALL.
    drive(32'h0800_0010, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h0000_000C, 32'h0, 32'h0, 32'h4, 1'b1, 1'b0, 1'b0);
    step();
    check("sys4_pc", pc, 32'h44);
    check("sys4_halted", 32'(halted), 32'd0);

    // Reset mid-HALT together with go and clr_stats.
    drive(32'h0800_0010, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive(32'h0000_000C, 32'h0, 32'h0, 32'hA, 1'b1, 1'b0, 1'b0);
    step();
    rst = 1'b0; go = 1'b1; clr_stats = 1'b1;
    step();
    check("rst_halt_pc", pc, 32'h0);
    check("rst_halt_halted", 32'(halted), 32'd0);
    check("rst_halt_unc", 32'(uncond_cnt), 32'd0);
    rst = 1'b1; go = 1'b0; clr_stats = 1'b0;

    // clr_stats alongside a J.
    drive(32'h0808_4210, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    check("clr_j_unc", 32'(uncond_cnt), 32'd0);
    check("clr_j_pc", pc, 32'h0021_0840);
    clr_stats = 1'b0;

    // Randomized run.
    for (int i = 0; i < 1500; i++) begin
      rs = $urandom;
      rt = ($urandom_range(0, 1) == 0) ? rs : 32'($urandom);
      drive(rand_instr(), rs, rt,
            ($urandom_range(0, 1) == 0) ? 32'hA : 32'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 8), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 31) == 0));
      rst = ($urandom_range(0, 99) != 0);
      step();
    end
    rst = 1'b1;
    #1 check_state();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/npc_seq.md
Name: npc_seq

Overview:
- Parametrised next-PC sequencer for the MIPS CPU; successor to the combinational NPC.
- Owns the PC register and computes the next PC for J, JAL, JR, BEQ, BNE and SYSCALL.
- Adds a RUN/HALT state machine: a syscall with a halt code stops the PC until `go` is pulsed.
- Keeps saturating branch-statistics counters of parametrised width, clearable at run time.
- Sits between instruction memory and the register file in the single-cycle datapath.

Parameters:
- ADDR_W, 32, PC width; must be at least 28.
- CNT_W, 16, width of each statistics counter.
- RESET_PC, 0, PC value loaded on reset.
- HALT_CODE, 32'hA, `sys_val` value that makes SYSCALL halt.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- en  in  1  advance enable; 0 = stall.
- go  in  1  resume pulse; acted on only in HALT.
- clr_stats  in  1  synchronous clear of all counters.
- instr  in  32  current instruction.
- rs_val  in  32  register-file rs read data.
- rt_val  in  32  register-file rt read data.
- sys_val  in  32  $v0 value for SYSCALL.
- pc  out  ADDR_W  current PC, registered.
- next_pc  out  ADDR_W  combinational next PC.
- link_pc  out  ADDR_W  pc+4, used by JAL writeback.
- halted  out  1  1 while in HALT.
- uncond_cnt  out  CNT_W  count of J/JAL/JR instructions.
- cond_cnt  out  CNT_W  count of BEQ/BNE instructions.
- cond_taken_cnt  out  CNT_W  count of taken BEQ/BNE.

Behaviour:
- Reset (rst=0 at a clk edge):
  - pc=RESET_PC, state=RUN, halted=0, all counters=0.
  - Reset overrides en, go and clr_stats, and applies in any state, including mid-HALT.
- Decode:
  - op=instr[31:26], funct=instr[5:0].
  - J: op 000010. JAL: op 000011.
  - JR: op 0, funct 001000. SYSCALL: op 0, funct 001100.
  - BEQ: op 000100. BNE: op 000101.
  - Every other encoding is sequential.
- next_pc, combinational, with p4 = pc+4 (mod 2^ADDR_W):
  - J/JAL: {p4[ADDR_W-1:28], instr[25:0], 2'b00}.
  - JR: rs_val[ADDR_W-1:0]; no alignment check.
  - BEQ/BNE taken: p4 + (sign-extend(instr[15:0]) << 2), wrapping at ADDR_W.
  - BEQ/BNE not taken: p4.
  - Taken condition: BEQ when rs_val==rt_val; BNE when rs_val!=rt_val.
  - SYSCALL with sys_val==HALT_CODE: pc (hold). SYSCALL otherwise: p4.
  - Default: p4.
  - In HALT: next_pc = pc.
- RUN state, en=1, each edge:
  - pc <= next_pc.
  - Halting SYSCALL: state <= HALT; halted rises the following cycle; pc stays on the SYSCALL.
- RUN state, en=0:
  - pc, state and counters hold.
  - A halting SYSCALL is not acted on until en=1.
- HALT state:
  - pc and counters hold.
  - en and instr are ignored.
  - go=1: state <= RUN and pc <= pc+4 in the same edge, so execution resumes after the SYSCALL.
- Counters, updated only on RUN edges with en=1:
  - uncond_cnt += 1 on J/JAL/JR.
  - cond_cnt += 1 on BEQ/BNE.
  - cond_taken_cnt += 1 on a taken BEQ/BNE.
  - Each counter saturates at 2^CNT_W-1 and does not wrap.
  - clr_stats=1 sets all counters to 0 regardless of state or en; clear beats a simultaneous increment.
- All outputs except next_pc and link_pc are registered; pc updates with 1-cycle latency.

Decomposition:
- Package npc_pkg:
  - Opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE.
  - Funct constants: FN_JR, FN_SYSCALL.
  - State enum npc_state_t {RUN, HALT}.
- Sub-module npc_sat_counter:
  - Parameter W; inputs inc, clr; output cnt.
  - Saturating, with clr priority.
  - Instantiated three times.

Test Plan:
- J at pc=0: instr=32'h08084210, en=1 -> next_pc=32'h00210840; pc=32'h00210840 after the edge; uncond_cnt=1.
- JR: instr=32'h00000008, rs_val=32'hFFFFFFFC -> pc=32'hFFFFFFFC. BNE at that pc with rs=rt=0, imm=16'hFFFE -> not taken, pc wraps to 32'h00000000; cond_cnt=1, cond_taken_cnt=0.
- BEQ at pc=32'h100: instr=32'h1000FFFF, rs=rt=32'hFFFFFFFF -> next_pc=32'h100 (self-loop); cond_taken_cnt increments each cycle.
  - With CNT_W=4, hold for 20 cycles -> cond_taken_cnt stays at 4'hF.
- SYSCALL at pc=32'h40: instr=32'h0000000C, sys_val=32'hA -> halted=1, pc holds 32'h40 for 10 cycles while en=1 and instr changes.
  - go pulse -> halted=0, pc=32'h44.
  - Repeat with sys_val=32'h4 -> no halt, pc=32'h44.
- rst=0 asserted mid-HALT together with go and clr_stats -> pc=RESET_PC, halted=0, counters=0 next edge.
  - clr_stats asserted alongside a J -> uncond_cnt=0.
- en=0 for 5 cycles during a BEQ-taken stream -> pc and all counters frozen; they resume on en=1.
